// File: rtl/keycode_command_reader.sv
// -----------------------------------------------------------------------------
// keycode_command_reader
//
// Purpose:
//   Decodes the 32-bit HID keycode word written by the NIOS II software into
//   single game commands (left, right, down, rotate-left, rotate-right). The
//   commands are paced to the frame tick and offered to block_logic on a
//   valid/ready handshake. A press edge fires immediately. When the
//   KEYCODE_AUTOREPEAT_EN macro is defined, held left/right/down keys
//   auto-repeat: the first repeat comes after DAS_FRAMES ticks and later repeats
//   come every ARR_FRAMES ticks. When the macro is undefined, every command
//   fires on press edges only.
//
// Parameters:
//   DAS_FRAMES  ticks from first emission to first auto-repeat (1..255)
//   ARR_FRAMES  ticks between later auto-repeats (1..255)
//
// Ports:
//   Clk                    in   1  system clock
//   Reset                  in   1  synchronous, active-high reset
//   keycode                in  32  four HID keycode bytes, 0x00 = empty slot
//   frame_clk_rising_edge  in   1  one-cycle frame tick
//   cmd_ready              in   1  consumer accepts cmd when high with cmd_valid
//   cmd                    out  5  one-hot {rot_r, rot_l, down, right, left}
//   cmd_valid              out  1  cmd holds a pending command
//   cmd_overflow           out  1  sticky: a command was dropped on a full slot
// -----------------------------------------------------------------------------
module keycode_command_reader #(
    parameter int unsigned DAS_FRAMES = 10,
    parameter int unsigned ARR_FRAMES = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] keycode,
    input  logic        frame_clk_rising_edge,
    input  logic        cmd_ready,
    output logic [4:0]  cmd,
    output logic        cmd_valid,
    output logic        cmd_overflow
);

    // HID usage codes
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_Z     = 8'h1D;
    localparam logic [7:0] KEY_X     = 8'h1B;
    localparam logic [7:0] KEY_UP    = 8'h52;

    // Output slot states
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    // An out-of-range timing parameter has no defined behaviour. This block
    // keeps the legal range visible in the elaborated hierarchy of both builds.
    if (DAS_FRAMES < 1 || DAS_FRAMES > 255 || ARR_FRAMES < 1 || ARR_FRAMES > 255)
    begin : g_timing_param_out_of_range
    end

    logic [31:0] keycode_q, keycode_d;
    logic [4:0]  prev_q, prev_d;
    logic [4:0]  cmd_q, cmd_d;
    logic [0:0]  state_q, state_d;
    logic        overflow_q, overflow_d;

    logic [4:0]  key_raw;
    logic [4:0]  pressed;
    logic [4:0]  press_edge;
    logic [4:0]  candidate;
    logic [4:0]  winner;
    logic        have_winner;

    function automatic logic key_hit(input logic [31:0] word, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (word[8*b +: 8] == code) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Decode always works on the registered word, so keycode needs to settle
    // one cycle before the tick it should affect.
    assign keycode_d = keycode;

    always_comb begin
        key_raw[0] = key_hit(keycode_q, KEY_LEFT);
        key_raw[1] = key_hit(keycode_q, KEY_RIGHT);
        key_raw[2] = key_hit(keycode_q, KEY_DOWN);
        key_raw[3] = key_hit(keycode_q, KEY_Z);
        key_raw[4] = key_hit(keycode_q, KEY_X) | key_hit(keycode_q, KEY_UP);
    end

    // Opposing directions cancel. The masked vector is also what goes into
    // prev, so releasing one of the pair turns the other into a fresh press.
    always_comb begin
        pressed = key_raw;
        if (key_raw[0] && key_raw[1]) begin
            pressed[1:0] = 2'b00;
        end
    end

    assign press_edge = pressed & ~prev_q;
    assign prev_d     = frame_clk_rising_edge ? pressed : prev_q;

`ifdef KEYCODE_AUTOREPEAT_EN
    localparam logic [7:0] DAS_LOAD = 8'(DAS_FRAMES);
    localparam logic [7:0] ARR_LOAD = 8'(ARR_FRAMES);

    logic [2:0] repeat_fire;

    // One repeat counter per movement key (bit order matches cmd[2:0]).
    // Counters advance on every tick, whether or not their key wins arbitration.
    for (genvar gi = 0; gi < 3; gi++) begin : g_repeat
        logic [7:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (frame_clk_rising_edge) begin
                if (!pressed[gi]) begin
                    cnt_d = 8'd0;
                end else if (press_edge[gi]) begin
                    cnt_d = DAS_LOAD;
                end else if (cnt_q == 8'd1) begin
                    cnt_d = ARR_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        end

        assign repeat_fire[gi] = pressed[gi] && !press_edge[gi] && (cnt_q == 8'd1);

        always_ff @(posedge Clk) begin
            if (Reset) begin
                cnt_q <= 8'd0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign candidate = press_edge | {2'b00, repeat_fire};
`else
    assign candidate = press_edge;
`endif

    // Fixed priority: rotate-right > rotate-left > down > left > right.
    always_comb begin
        winner = 5'b00000;
        if (frame_clk_rising_edge) begin
            if (candidate[4]) begin
                winner = 5'b10000;
            end else if (candidate[3]) begin
                winner = 5'b01000;
            end else if (candidate[2]) begin
                winner = 5'b00100;
            end else if (candidate[0]) begin
                winner = 5'b00001;
            end else if (candidate[1]) begin
                winner = 5'b00010;
            end
        end
    end

    assign have_winner = |winner;

    // Single-entry output slot. A full slot that is accepted in the same cycle
    // as a new winner takes the new command directly. A full slot that is not
    // accepted keeps its command and flags the dropped one.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        overflow_d = overflow_q;
        case (state_q)
            S_EMPTY: begin
                if (have_winner) begin
                    state_d = S_FULL;
                    cmd_d   = winner;
                end
            end
            default: begin
                if (cmd_ready) begin
                    if (have_winner) begin
                        cmd_d = winner;
                    end else begin
                        state_d = S_EMPTY;
                        cmd_d   = 5'b00000;
                    end
                end else if (have_winner) begin
                    overflow_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            keycode_q  <= 32'd0;
            prev_q     <= 5'd0;
            cmd_q      <= 5'd0;
            state_q    <= S_EMPTY;
            overflow_q <= 1'b0;
        end else begin
            keycode_q  <= keycode_d;
            prev_q     <= prev_d;
            cmd_q      <= cmd_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    assign cmd          = cmd_q;
    assign cmd_valid    = (state_q == S_FULL);
    assign cmd_overflow = overflow_q;

endmodule

// File: tb/tb_keycode_command_reader.sv
module tb_keycode_command_reader;

    localparam int DAS = 10;
    localparam int ARR = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] keycode = 32'd0;
    logic        tick = 1'b0;
    logic        cmd_ready = 1'b0;
    logic [4:0]  cmd;
    logic        cmd_valid;
    logic        cmd_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_kc_q;
    logic [4:0]  m_prev;
    int          m_hold [3];
    logic        m_valid;
    logic [4:0]  m_cmd;
    logic        m_ovf;

    keycode_command_reader #(
        .DAS_FRAMES(DAS),
        .ARR_FRAMES(ARR)
    ) dut (
        .Clk                  (clk),
        .Reset                (reset),
        .keycode              (keycode),
        .frame_clk_rising_edge(tick),
        .cmd_ready            (cmd_ready),
        .cmd                  (cmd),
        .cmd_valid            (cmd_valid),
        .cmd_overflow         (cmd_overflow)
    );

    always #5 clk = ~clk;

`ifdef KEYCODE_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    function automatic bit has_key(input logic [31:0] w, input logic [7:0] code);
        for (int b = 0; b < 4; b++) begin
            if (w[8*b +: 8] == code) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Behavioural model: a movement key held for n ticks since its press emits
    // at n==0, n==DAS and every ARR ticks after that. The output is a
    // one-entry slot that is drained by acceptance before any refill.
    task automatic model_update(input logic [31:0] kc, input logic tk, input logic rdy,
                                input logic rst);
        logic [4:0] pr;
        logic [4:0] edg;
        logic [4:0] emit;
        logic [4:0] win;
        int order [5];
        if (rst) begin
            m_kc_q = 32'd0;
            m_prev = 5'd0;
            m_hold[0] = 0;
            m_hold[1] = 0;
            m_hold[2] = 0;
            m_valid = 1'b0;
            m_cmd = 5'd0;
            m_ovf = 1'b0;
            return;
        end
        win = 5'd0;
        if (tk) begin
            pr[0] = has_key(m_kc_q, 8'h50);
            pr[1] = has_key(m_kc_q, 8'h4F);
            pr[2] = has_key(m_kc_q, 8'h51);
            pr[3] = has_key(m_kc_q, 8'h1D);
            pr[4] = has_key(m_kc_q, 8'h1B) || has_key(m_kc_q, 8'h52);
            if (pr[0] && pr[1]) pr[1:0] = 2'b00;
            edg  = pr & ~m_prev;
            emit = edg;
            for (int k = 0; k < 3; k++) begin
                if (!pr[k]) m_hold[k] = 0;
                else if (edg[k]) m_hold[k] = 0;
                else m_hold[k] = m_hold[k] + 1;
                if (AUTOREP && pr[k] && !edg[k] &&
                    (m_hold[k] == DAS || (m_hold[k] > DAS && (m_hold[k] - DAS) % ARR == 0)))
                    emit[k] = 1'b1;
            end
            order = '{4, 3, 2, 0, 1};
            for (int i = 0; i < 5; i++) begin
                if (win == 5'd0 && emit[order[i]]) win[order[i]] = 1'b1;
            end
            m_prev = pr;
        end
        if (rdy && m_valid) begin
            $display("[TB] accept cmd=%b", m_cmd);
            m_valid = 1'b0;
            m_cmd = 5'd0;
        end
        if (win != 5'd0) begin
            if (m_valid) m_ovf = 1'b1;
            else begin
                m_valid = 1'b1;
                m_cmd = win;
            end
        end
        m_kc_q = kc;
    endtask

    // One clock cycle: drive on the falling edge, update the model at the
    // rising edge, leave outputs settled 1 time unit after it.
    task automatic step(input logic [31:0] kc, input logic tk, input logic rdy, input logic rst);
        @(negedge clk);
        keycode = kc;
        tick = tk;
        cmd_ready = rdy;
        reset = rst;
        @(posedge clk);
        model_update(kc, tk, rdy, rst);
        #1;
    endtask

    task automatic test_reset;
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(32'd0, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (cmd !== 5'd0) begin n_fail++; $display("FAIL reset_cmd got=%b exp=00000", cmd); end
        n_tests++;
        if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", cmd_valid); end
        n_tests++;
        if (cmd_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", cmd_overflow); end
    endtask

    task automatic test_left_repeat;
        logic exp_v;
        step(32'd0, 1'b0, 1'b1, 1'b1);
        for (int t = 0; t <= 20; t++) begin
            logic [31:0] kc;
            kc = (t <= 16) ? 32'h0000_0050 : 32'd0;
            repeat (3) step(kc, 1'b0, 1'b1, 1'b0);
            step(kc, 1'b1, 1'b1, 1'b0);
            exp_v = (t == 0) || (AUTOREP && (t == 10 || t == 13 || t == 16));
            n_tests++;
            if (cmd_valid !== exp_v || (exp_v && cmd !== 5'b00001)) begin
                n_fail++;
                $display("FAIL left_repeat tick=%0d got valid=%b cmd=%b exp valid=%b cmd=00001",
                         t, cmd_valid, cmd, exp_v);
            end
        end
    endtask

    task automatic test_rotate_pair;
        step(32'd0, 1'b0, 1'b1, 1'b1);
        step(32'h0000_1B1D, 1'b0, 1'b1, 1'b0);
        step(32'h0000_1B1D, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd !== 5'b10000) begin
            n_fail++;
            $display("FAIL rotate_pair got valid=%b cmd=%b exp valid=1 cmd=10000", cmd_valid, cmd);
        end
        for (int t = 0; t < 30; t++) begin
            step(32'h0000_1B1D, 1'b0, 1'b1, 1'b0);
            step(32'h0000_1B1D, 1'b1, 1'b1, 1'b0);
            n_tests++;
            if (cmd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rotate_no_repeat tick=%0d got valid=%b exp=0", t, cmd_valid);
            end
        end
    endtask

    task automatic test_left_right_cancel;
        step(32'd0, 1'b0, 1'b1, 1'b1);
        for (int t = 0; t < 6; t++) begin
            step(32'h0000_4F50, 1'b0, 1'b1, 1'b0);
            step(32'h0000_4F50, 1'b1, 1'b1, 1'b0);
            n_tests++;
            if (cmd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL lr_cancel tick=%0d got valid=%b cmd=%b exp valid=0", t, cmd_valid, cmd);
            end
        end
        step(32'h0000_0050, 1'b0, 1'b1, 1'b0);
        step(32'h0000_0050, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd !== 5'b00001) begin
            n_fail++;
            $display("FAIL lr_release_right got valid=%b cmd=%b exp valid=1 cmd=00001", cmd_valid, cmd);
        end
    endtask

    task automatic test_backpressure;
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(32'h0000_0051, 1'b0, 1'b0, 1'b0);
        step(32'h0000_0051, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd !== 5'b00100) begin
            n_fail++;
            $display("FAIL bp_first got valid=%b cmd=%b exp valid=1 cmd=00100", cmd_valid, cmd);
        end
        step(32'h0000_001B, 1'b0, 1'b0, 1'b0);
        step(32'h0000_001B, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (cmd !== 5'b00100 || cmd_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_overflow got cmd=%b ovf=%b exp cmd=00100 ovf=1", cmd, cmd_overflow);
        end
        step(32'h0000_001B, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (cmd_valid !== 1'b0 || cmd !== 5'd0 || cmd_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept got valid=%b cmd=%b ovf=%b exp valid=0 cmd=00000 ovf=1",
                     cmd_valid, cmd, cmd_overflow);
        end
    endtask

    task automatic test_back_to_back;
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(32'h0000_0051, 1'b0, 1'b0, 1'b0);
        step(32'h0000_0051, 1'b1, 1'b0, 1'b0);
        step(32'h0000_001D, 1'b0, 1'b0, 1'b0);
        step(32'h0000_001D, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd !== 5'b01000 || cmd_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back got valid=%b cmd=%b ovf=%b exp valid=1 cmd=01000 ovf=0",
                     cmd_valid, cmd, cmd_overflow);
        end
    endtask

    task automatic test_reset_midop;
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(32'h0000_0050, 1'b0, 1'b0, 1'b0);
        step(32'h0000_0050, 1'b1, 1'b0, 1'b0);
        step(32'h0000_0051, 1'b0, 1'b0, 1'b0);
        step(32'h0000_0050, 1'b1, 1'b0, 1'b0);
        step(32'h0000_0050, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (cmd_valid !== 1'b0 || cmd !== 5'd0 || cmd_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop got valid=%b cmd=%b ovf=%b exp all 0", cmd_valid, cmd, cmd_overflow);
        end
        step(32'h0000_0050, 1'b0, 1'b0, 1'b0);
        step(32'h0000_0050, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_repress got valid=%b cmd=%b exp valid=1 cmd=00001", cmd_valid, cmd);
        end
    endtask

    task automatic test_down_hold;
        int count;
        int exp_count;
        count = 0;
        exp_count = AUTOREP ? 11 : 1;
        step(32'd0, 1'b0, 1'b1, 1'b1);
        for (int t = 0; t < 40; t++) begin
            step(32'h0000_0051, 1'b0, 1'b1, 1'b0);
            step(32'h0000_0051, 1'b1, 1'b1, 1'b0);
            if (cmd_valid === 1'b1 && cmd === 5'b00100) count++;
        end
        n_tests++;
        if (count !== exp_count) begin
            n_fail++;
            $display("FAIL down_hold got count=%0d exp=%0d", count, exp_count);
        end
    endtask

    task automatic test_random;
        logic [31:0] kc;
        logic [7:0]  pool [8];
        int          errs;
        pool = '{8'h00, 8'h50, 8'h4F, 8'h51, 8'h1D, 8'h1B, 8'h52, 8'h00};
        errs = 0;
        kc = 32'd0;
        step(32'd0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(59, 0) == 0) begin
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(9, 0) == 0) kc[8*b +: 8] = 8'($urandom);
                    else kc[8*b +: 8] = pool[$urandom_range(7, 0)];
                end
            end
            step(kc, ($urandom_range(2, 0) == 0), 1'($urandom), ($urandom_range(499, 0) == 0));
            n_tests++;
            if (cmd_valid !== m_valid || cmd !== m_cmd || cmd_overflow !== m_ovf) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random cyc=%0d got valid=%b cmd=%b ovf=%b exp valid=%b cmd=%b ovf=%b",
                             c, cmd_valid, cmd, cmd_overflow, m_valid, m_cmd, m_ovf);
            end
        end
    endtask

    initial begin
        model_update(32'd0, 1'b0, 1'b0, 1'b1);
        test_reset;
        test_left_repeat;
        test_rotate_pair;
        test_left_right_cancel;
        test_backpressure;
        test_back_to_back;
        test_reset_midop;
        test_down_hold;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keycode_command_reader.md
# keycode_command_reader

Reads the 32-bit USB HID keycode word that the NIOS II software writes into the `keycode_export` PIO. Turns it into single game commands paced to the frame tick: left, right, down, rotate-left and rotate-right. The block sits between the NIOS system and `block_logic`, and offers each command on a valid/ready handshake. Press edges fire immediately; held movement keys auto-repeat with a delay then a fixed rate.

## Interface
- `DAS_FRAMES`, default 10: frame ticks from first emission to first auto-repeat; legal range 1..255.
- `ARR_FRAMES`, default 3: frame ticks between subsequent auto-repeats; legal range 1..255.
- `Clk  in  1`: system clock (CLOCK_50 domain).
- `Reset  in  1`: synchronous, active-high; all state clears on the next `Clk` edge.
- `keycode  in  32`: four HID keycode bytes, [7:0]..[31:24]; 0x00 marks an empty slot.
- `frame_clk_rising_edge  in  1`: one-cycle frame tick.
- `cmd_ready  in  1`: the consumer accepts `cmd` when this and `cmd_valid` are both high.
- `cmd  out  5`: one-hot command: [0] left, [1] right, [2] down, [3] rotate-left, [4] rotate-right.
- `cmd_valid  out  1`: `cmd` holds a pending command.
- `cmd_overflow  out  1`: sticky; a command was generated while the slot was full.

## Operation
- Key map: Left 0x50 -> left. Right 0x4F -> right. Down 0x51 -> down. Z 0x1D -> rotate-left. X 0x1B and Up 0x52 -> rotate-right.
- A key counts as pressed if any of the four bytes matches its code.
- `keycode` is registered every cycle into `keycode_q`, and decode works from `keycode_q`.
- All evaluation happens only in cycles where `frame_clk_rising_edge`=1 (a "tick").
- `prev[4:0]` stores the pressed vector at each tick.
- A press edge is pressed now and `prev`=0.
- If left and right are both pressed at a tick, both are treated as not pressed for edges and emission.
- Repeat counters (8-bit, one each for left/right/down):
  - On a press-edge tick: emit, and load the counter with `DAS_FRAMES`.
  - On a held tick with counter==1: emit, and load `ARR_FRAMES`.
  - On any other held tick: decrement the counter.
  - On release: clear the counter to 0.
  - Counters advance whether or not the emission wins arbitration.
- Rotations emit only on press edges and never repeat.
- Arbitration: at most one command per tick, priority rotate-right > rotate-left > down > left > right. Losing candidates are discarded.
- Output slot FSM has two states, EMPTY and FULL:
  - EMPTY --tick with winner--> FULL, loading `cmd`.
  - FULL --`cmd_ready`--> EMPTY.
  - FULL with `cmd_ready` and a winner in the same cycle --> stays FULL with the new `cmd`; no overflow.
  - FULL without `cmd_ready` and a winner --> stays FULL with the old `cmd` kept; the new command is dropped and `cmd_overflow` is set.
- `cmd` is stable while `cmd_valid`=1. `cmd`=0 whenever EMPTY.
- `cmd_overflow` clears only on `Reset`.

## Timing
- Reset values: `cmd`=0, `cmd_valid`=0, `cmd_overflow`=0, `prev`=0, counters=0, `keycode_q`=0, FSM=EMPTY.
- `keycode` must be stable at least one cycle before a tick (one-cycle input latency).
- A tick in cycle t gives `cmd_valid`=1 in cycle t+1.
- Acceptance in cycle t gives `cmd_valid`=0 in cycle t+1, unless reloaded by a tick in cycle t.
- Reset mid-operation drops any pending command. A key held through reset release is treated as a new press at the first tick.
- Tick and `Reset` in the same cycle: reset wins.

## Configuration
- `KEYCODE_AUTOREPEAT_EN` defined: DAS/ARR repeat for left/right/down as described above.
- Not defined: counters and repeat logic are not compiled. Every command emits only on press edges, and `DAS_FRAMES`/`ARR_FRAMES` are ignored.

## Test plan
- Left arrow: `keycode`=0x00000050 before tick 0, held with `cmd_ready`=1 (DAS=10, ARR=3, macro on) -> left emitted at ticks 0, 10, 13, 16; after release at tick 17, no more emissions.
- Z and X together: `keycode`=0x00001B1D -> only `cmd`=5'b10000 (rotate-right) at that tick; holding for 30 ticks gives no repeats.
- Left and right together: `keycode`=0x00004F50 -> no command on any tick; releasing right leaves left held (`keycode`=0x00000050), which is a press edge -> left emitted at the next tick.
- Backpressure: `cmd_ready`=0, down press (`keycode`=0x00000051) then an X press on a later tick -> `cmd` stays 5'b00100, `cmd_overflow`=1. Raise `cmd_ready` for one cycle -> `cmd_valid`=0 the next cycle.
- Reset: pulse `Reset` while a command is pending and left is held -> all outputs 0 the next cycle; the first tick after reset emits left.
- Macro undefined: hold down for 40 ticks -> exactly one down command.
